// File: rtl/vga_pixel_stream_if.sv
// Producer-to-pixel-buffer handshake: one {sof, rgb} pixel per accepted valid/ready beat.
interface vga_pixel_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_rgb;
  logic        in_sof;

  modport master (output in_valid, output in_rgb, output in_sof, input in_ready);
  modport slave  (input in_valid, input in_rgb, input in_sof, output in_ready);
endinterface

// File: rtl/vga_pixel_stream.sv
// Pixel FIFO in front of the VGA output stage; aligns each frame to frame_start via the SOF tag
// and blanks the rest of a frame to black on underflow or misalignment.
module vga_pixel_stream #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  vga_pixel_stream_if.slave     pix_in,
  input  logic                  pix_en,
  input  logic                  active,
  input  logic                  frame_start,
  output logic [7:0]            VGA_R,
  output logic [7:0]            VGA_G,
  output logic [7:0]            VGA_B,
  output logic                  underflow,
  output logic                  misalign,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {SYNC = 1'b0, STREAM = 1'b1} state_t;

  logic [24:0]         r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  state_t              r_state;
  state_t              w_state_next;
  logic [23:0]         r_rgb;
  logic                r_underflow;
  logic                r_misalign;

  logic        w_full;
  logic        w_empty;
  logic [24:0] w_head;
  logic        w_head_sof;
  logic        w_push;
  logic        w_due;
  logic        w_fs;
  logic        w_pop;
  logic        w_show;
  logic        w_start;
  logic        w_set_uf;
  logic        w_set_mis;

  assign w_full     = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                      (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_head     = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign w_head_sof = w_head[24];
  assign w_push     = pix_in.in_valid & ~w_full;
  assign w_due      = pix_en & active;
  assign w_fs       = frame_start & w_due;

  // Storage has no reset: after reset the pointers alone define what is valid.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {pix_in.in_sof, pix_in.in_rgb};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SYNC:    if (!w_empty && w_head_sof && w_fs) w_state_next = STREAM;
      STREAM:  if (w_due && (w_empty || (w_head_sof != w_fs))) w_state_next = SYNC;
      default: w_state_next = SYNC;
    endcase
  end

  // In SYNC untagged pixels are flushed at full clock rate so the SOF pixel reaches the head fast.
  always_comb begin
    w_pop     = 1'b0;
    w_show    = 1'b0;
    w_start   = 1'b0;
    w_set_uf  = 1'b0;
    w_set_mis = 1'b0;
    case (r_state)
      SYNC: begin
        if (!w_empty) begin
          if (!w_head_sof) begin
            w_pop = 1'b1;
          end else if (w_fs) begin
            w_pop   = 1'b1;
            w_show  = 1'b1;
            w_start = 1'b1;
          end
        end
      end
      STREAM: begin
        if (w_due) begin
          if (w_empty) begin
            w_set_uf = 1'b1;
          end else if (w_head_sof != w_fs) begin
            w_set_mis = 1'b1;
          end else begin
            w_pop  = 1'b1;
            w_show = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rgb       <= '0;
      r_underflow <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Colour only changes on a strobe, so each pixel is held for the full pixel period.
      if (pix_en) r_rgb <= w_show ? w_head[23:0] : 24'd0;
      r_underflow <= w_set_uf  | (r_underflow & ~w_start);
      r_misalign  <= w_set_mis | (r_misalign  & ~w_start);
    end
  end

  assign pix_in.in_ready = ~w_full;
  assign level           = r_wr_ptr - r_rd_ptr;
  assign VGA_R           = r_rgb[23:16];
  assign VGA_G           = r_rgb[15:8];
  assign VGA_B           = r_rgb[7:0];
  assign underflow       = r_underflow;
  assign misalign        = r_misalign;

endmodule

// File: doc/vga_pixel_stream.md
# vga_pixel_stream

Buffered pixel source sitting directly upstream of the VGA output stage on the `CLOCK_50` domain. It accepts RGB pixels from a producer over a valid/ready handshake, stores them in a small FIFO, and releases one pixel per 25 MHz pixel strobe during the active video region. Each frame is locked to the timing generator's frame-start pulse using a start-of-frame tag carried with the pixels. It reports underflow and misalignment so that a late producer shows up as a black frame remainder, not a torn image.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries (default 16).
- `CLOCK_50`  in  1  system clock, 50 MHz, all logic rising-edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a pixel on `in_rgb`/`in_sof`.
- `in_ready`  out  1  FIFO can accept; equals not-full.
- `in_rgb`  in  24  pixel, {R[23:16], G[15:8], B[7:0]}.
- `in_sof`  in  1  marks the first pixel of a frame.
- `pix_en`  in  1  one-cycle pixel strobe, every second `CLOCK_50` cycle.
- `active`  in  1  visible region, valid when `pix_en`=1.
- `frame_start`  in  1  high only with `pix_en`&`active` on pixel (0,0).
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  registered pixel colour.
- `underflow`  out  1  sticky; FIFO was empty when a pixel was due.
- `misalign`  out  1  sticky; SOF tag and `frame_start` disagreed.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.

## Operation
- FIFO entry is 25 bits, {sof, rgb}. Read/write pointers are DEPTH_LOG2+1 bits. Full when the MSBs differ and the rest are equal. Empty when equal. Pointers wrap naturally.
- Push: `in_valid & in_ready`. `in_ready` = !full, combinational from registered pointers.
- Pixel due: `pix_en & active`.
- State machine, two states:
  - SYNC (reset state):
    - If not empty and head sof=0: pop and discard, one entry per cycle, independent of `pix_en`.
    - If head sof=1: hold until `frame_start`. Then pop, drive the pixel, go to STREAM.
    - Any due pixel not popped outputs 0.
  - STREAM: on each due pixel:
    - Empty: output 0, set `underflow`, go to SYNC.
    - Head sof=1 without `frame_start`: output 0, set `misalign`, do not pop, go to SYNC.
    - `frame_start` with head sof=0: output 0, set `misalign`, go to SYNC.
    - Otherwise: pop and output the head.
- When no pixel is due or `active`=0, the next output is 0 (blanking black).
- `underflow`/`misalign` clear on the cycle after a `frame_start` that successfully starts a frame (SYNC→STREAM). A new error in that same cycle wins.
- Simultaneous push and pop: both happen, `level` unchanged. When full, a pop frees a slot, but `in_ready` rises only the next cycle.
- Reset mid-frame: pointers, state, and all outputs clear immediately. The FIFO contents are discarded.

## Timing
- Reset values: `VGA_R/G/B`=0, `in_ready`=1, `underflow`=0, `misalign`=0, `level`=0, state SYNC.
- Latency:
  - A popped pixel appears on `VGA_*` one `CLOCK_50` cycle after its `pix_en` cycle.
  - The pixel is held for 2 cycles, until the next strobe updates it.
- A pushed entry is poppable from the next cycle. Minimum push-to-display is 1 cycle plus the wait for `pix_en`.
- `level` updates the cycle after the push/pop.
- Sustained input rate is limited only by `in_ready`: 1 pixel per cycle.

## Test plan
- Reset: hold `RESET_N`=0 with `in_valid`=1 → `in_ready`=1, `level`=0, RGB=0, no pushes counted. After release, 16 pushes → `level`=16, `in_ready`=0.
- Aligned stream:
  - Push SOF pixel 0x112233, then 0x445566, 0x778899.
  - Pulse `frame_start` on the first due strobe.
  - → `VGA_*` shows 11/22/33, 44/55/66, 77/88/99 on consecutive strobes, 1 cycle after each. No flags set.
- Discard to sync: push 3 pixels with sof=0, then an SOF pixel 0xFF0000 → the first 3 are dropped within 3 cycles, `level`=1, and red appears after `frame_start`.
- Underflow: in STREAM, let the FIFO drain → the next due pixel outputs 0, `underflow`=1, state SYNC. The flag clears the cycle after the next good `frame_start`.
- Misalignment: in STREAM, the head is an SOF pixel while `frame_start`=0 → output 0, `misalign`=1, `level` unchanged.
- Full boundary: fill to 16, then push and pop in the same cycle → `level` goes 16→15, `in_ready`=1 next cycle, no overwrite of unread data.
